regfile_mp: RTL

Parametrised multi-port register file for the pipelined CPU, replacing the fixed 2-read/1-write file in the decode stage. It adds configurable width, depth, read ports and write ports, with write-through bypass from every write port. It also carries a per-register busy scoreboard so decode can detect pending producers such as outstanding loads or multi-cycle ops. Register 0 is optionally hardwired to zero.

---
 rtl/cpu_rf_pkg.sv | 26 ++
 rtl/rf_read_port.sv | 46 ++++
 rtl/regfile_mp.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_rf_pkg.sv
// Shared register-file types and helpers.
// Default widths, the zero-register address and port-vector slicing.
package cpu_rf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    // Widest packed port vector and widest field the slicer handles.
    localparam int VEC_MAX = 256;
    localparam int FLD_MAX = 64;

    // Extract field idx of width w from a packed port vector.
    function automatic logic [FLD_MAX-1:0] port_slice(
        input logic [VEC_MAX-1:0] vec,
        input int                 idx,
        input int                 w
    );
        logic [VEC_MAX-1:0] s;
        logic [FLD_MAX-1:0] m;
        s = vec >> (idx * w);
        m = (FLD_MAX'(1) << w) - FLD_MAX'(1);
        return s[FLD_MAX-1:0] & m;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One register-file read port.
// Zero decode, write-through bypass priority mux and busy masking.
module rf_read_port
    import cpu_rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NWR      = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_W-1:0]     mem [2**ADDR_W],
    input  logic [2**ADDR_W-1:0]  busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_busy
);

    localparam logic [ADDR_W-1:0] ZA = ADDR_W'(REG_ZERO);

    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;

    // Stored value unless an enabled write hits; later ports override.
    always_comb begin
        rd_data = mem[rd_addr];
        rd_busy = busy[rd_addr];
        wa      = '0;
        wd      = '0;
        for (int w = 0; w < NWR; w++) begin
            wa = ADDR_W'(port_slice(VEC_MAX'(wr_addr), w, ADDR_W));
            wd = DATA_W'(port_slice(VEC_MAX'(wr_data), w, DATA_W));
            if (wr_en[w] && (wa == rd_addr)) begin
                rd_data = wd;
                rd_busy = 1'b0;
            end
        end
        if (ZERO_REG && (rd_addr == ZA)) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-through bypass.
// Holds storage, the busy scoreboard and its population count.
module regfile_mp
    import cpu_rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic [ADDR_W:0]       busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CW    = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] ZA = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [CW-1:0]     busy_cnt_q, busy_cnt_d;

    logic [ADDR_W-1:0] wa [NWR];
    logic [DATA_W-1:0] wd [NWR];
    logic [DEPTH-1:0]  clr, set;
    logic [CW-1:0]     dec;
    logic              inc;

    // Unpack write ports.
    always_comb begin
        for (int w = 0; w < NWR; w++) begin
            wa[w] = ADDR_W'(port_slice(VEC_MAX'(wr_addr), w, ADDR_W));
            wd[w] = DATA_W'(port_slice(VEC_MAX'(wr_data), w, DATA_W));
        end
    end

    // Next storage: higher write port applied last so it wins.
    always_comb begin
        mem_d = mem_q;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && !(ZERO_REG && (wa[w] == ZA))) begin
                mem_d[wa[w]] = wd[w];
            end
        end
        if (ZERO_REG) begin
            mem_d[0] = '0;
        end
    end

    // Scoreboard: writes clear, issue sets, a re-issue beats completion.
    always_comb begin
        clr = '0;
        set = '0;
        dec = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w]) begin
                clr[wa[w]] = 1'b1;
            end
        end
        if (iss_en && !(ZERO_REG && (iss_addr == ZA))) begin
            set[iss_addr] = 1'b1;
        end
        busy_d = (busy_q & ~clr) | set;
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end
        inc = |(set & ~busy_q);
        for (int i = 0; i < DEPTH; i++) begin
            dec = dec + CW'(busy_q[i] & clr[i] & ~set[i]);
        end
        busy_cnt_d = busy_cnt_q + CW'(inc) - dec;
    end

    // State registers; reset wipes storage and scoreboard at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q      <= '{default: '0};
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NWR      (NWR),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .rd_addr (rd_addr[p*ADDR_W +: ADDR_W]),
            .mem     (mem_q),
            .busy    (busy_q),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_data (rd_data[p*DATA_W +: DATA_W]),
            .rd_busy (rd_busy[p])
        );
    end

endmodule
